// File: rtl/data_mem_ctrl_if.sv
// LSU <-> data-memory request/response bus: strobe/ack handshake with error qualifier.
interface data_mem_ctrl_if;
  logic        i_stb;
  logic        i_wr_en;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_write_data;
  logic        o_busy;
  logic        o_ack;
  logic        o_err;
  logic [31:0] o_read_data;

  modport master (
    output i_stb, i_wr_en, i_size, i_unsigned, i_addr, i_write_data,
    input  o_busy, o_ack, o_err, o_read_data
  );

  modport slave (
    input  i_stb, i_wr_en, i_size, i_unsigned, i_addr, i_write_data,
    output o_busy, o_ack, o_err, o_read_data
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory slave with byte/half/word access,
// sign/zero extension, programmable latency and error response.
module data_mem_ctrl #(
  parameter logic [31:0] DATA_START  = 32'h0000_2000,
  parameter int          DEPTH_BYTES = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam logic [2:0]  WAIT_INIT = 3'(LATENCY - 1);
  localparam logic [32:0] LIMIT     = {1'b0, DATA_START} + 33'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  req_t        req_in, req_q, cur;
  logic        accept, commit, cur_err, misalign, err_q;
  logic [32:0] a33, end33;
  logic [AW-1:0] idx;
  logic [7:0]  b [4];
  logic [31:0] load_val, rdata_q;
  logic [7:0]  mem [DEPTH_BYTES];

  assign req_in = '{wr: bus.i_wr_en, size: bus.i_size, uns: bus.i_unsigned,
                    addr: bus.i_addr, wdata: bus.i_write_data};
  assign accept = bus.i_stb && (state == IDLE || state == RESP);

  // With single-cycle latency the access completes on the acceptance edge itself,
  // so the array sees the live request instead of the captured copy.
  assign cur    = (LATENCY == 1) ? req_in : req_q;
  assign commit = rst_n && ((LATENCY == 1) ? accept : (state == WAIT && cnt == 3'd1));

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= WAIT_INIT;
      else if (state == WAIT)  cnt <= cnt - 3'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_stb) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = bus.i_stb ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.o_busy      = 1'b0;
    bus.o_ack       = 1'b0;
    bus.o_err       = 1'b0;
    bus.o_read_data = '0;
    case (state)
      WAIT: bus.o_busy = 1'b1;
      RESP: begin
        bus.o_ack       = 1'b1;
        bus.o_err       = err_q;
        bus.o_read_data = rdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else if (accept) req_q <= req_in;
  end

  // 33-bit range arithmetic so addresses near 32'hFFFF_FFFF cannot wrap into range
  always_comb begin
    a33      = {1'b0, cur.addr};
    end33    = a33 + (33'd1 << cur.size);
    misalign = (cur.size == 2'b01 && cur.addr[0]) ||
               (cur.size == 2'b10 && cur.addr[1:0] != 2'b00);
    cur_err  = (cur.size == 2'b11) || misalign ||
               (a33 < {1'b0, DATA_START}) || (end33 > LIMIT);
    idx      = AW'(cur.addr - DATA_START);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) b[i] = mem[idx + AW'(i)];
    case (cur.size)
      2'b00:   load_val = {{24{~cur.uns & b[0][7]}}, b[0]};
      2'b01:   load_val = {{16{~cur.uns & b[1][7]}}, b[1], b[0]};
      default: load_val = {b[3], b[2], b[1], b[0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (commit) begin
      err_q   <= cur_err;
      rdata_q <= (cur_err || cur.wr) ? '0 : load_val;
    end
  end

  // Array is never reset; only the addressed bytes of a legal store change
  always_ff @(posedge clk) begin
    if (commit && cur.wr && !cur_err) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << cur.size)) mem[idx + AW'(i)] <= cur.wdata[8*i +: 8];
    end
  end
endmodule
